// File: rtl/div_uint_multicycle_pkg.sv
// Shared state encoding and sizing helpers for the multi-cycle unsigned divider.
package div_uint_multicycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_CALC = 3'b010,
    ST_DONE = 3'b100
  } div_state_e;

  // The shifted divisor must hold divisor << (DIVIDEND_W-1) without loss.
  function automatic int unsigned div_cmp_width(input int unsigned dividend_w,
                                                input int unsigned divisor_w);
    return dividend_w + divisor_w - 32'd1;
  endfunction

endpackage

// File: rtl/div_uint_multicycle_if.sv
// AXIS-style operand/result bundle for the divider.
// slave is the divider's view; master is the view of whoever feeds it and drains it.
interface div_uint_multicycle_if #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 3,
  parameter int unsigned USER_W     = 1
);

  logic [DIVISOR_W+DIVIDEND_W-1:0] s_axis_data;
  logic [USER_W-1:0]               s_axis_user;
  logic                            s_axis_valid;
  logic                            s_axis_ready;
  logic [DIVISOR_W+DIVIDEND_W-1:0] m_axis_data;
  logic [USER_W-1:0]               m_axis_user;
  logic                            m_axis_div_zero;
  logic                            m_axis_valid;
  logic                            m_axis_ready;

  modport slave (
    input  s_axis_data, s_axis_user, s_axis_valid, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_user, m_axis_div_zero, m_axis_valid
  );

  modport master (
    output s_axis_data, s_axis_user, s_axis_valid, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_user, m_axis_div_zero, m_axis_valid
  );

endinterface

// File: rtl/div_uint_multicycle_cmp_sub_step.sv
// One restoring-division step: conditional subtract of the aligned divisor.
module div_cmp_sub_step #(
  parameter int unsigned CMP_W = 18
) (
  input  logic [CMP_W-1:0] rem_i,
  input  logic [CMP_W-1:0] cmp_i,
  output logic             ge_o,
  output logic [CMP_W-1:0] rem_next_o,
  output logic             rem_next_is_zero_o
);

  // Subtract only when the aligned divisor fits; otherwise the remainder is restored.
  always_comb begin
    ge_o = (rem_i >= cmp_i);
    if (ge_o) begin
      rem_next_o = rem_i - cmp_i;
    end else begin
      rem_next_o = rem_i;
    end
    rem_next_is_zero_o = (rem_next_o == {CMP_W{1'b0}});
  end

endmodule

// File: rtl/div_uint_multicycle.sv
// Multi-cycle restoring unsigned divider: one quotient bit per enabled clock,
// early exit once the partial remainder is zero, divide-by-zero flagged.
module div_uint_multicycle
  import div_uint_multicycle_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 3,
  parameter int unsigned USER_W     = 1,
  parameter int unsigned SIM_DELAY  = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 aclken,
  div_uint_multicycle_if.slave axis
);

  localparam int unsigned CMP_W = div_cmp_width(DIVIDEND_W, DIVISOR_W);
  localparam int unsigned K_W   = $clog2(DIVIDEND_W);

  // Reject configurations outside the supported range at elaboration.
  generate
    if ((DIVIDEND_W < 32'd2) || (DIVIDEND_W > 32'd32) || (DIVISOR_W < 32'd1) ||
        (DIVISOR_W > DIVIDEND_W) || (USER_W < 32'd1) || (SIM_DELAY > 32'd1000)) begin : g_bad_param
      $error("div_uint_multicycle: unsupported parameter combination");
    end
  endgenerate

  div_state_e             state_q;
  logic [K_W-1:0]         k_q;
  logic [CMP_W-1:0]       rem_q, rem_d;
  logic [CMP_W-1:0]       cmp_q, cmp_d;
  logic [DIVIDEND_W-1:0]  quo_q, quo_d;
  logic [USER_W-1:0]      user_q, user_d;
  logic                   dz_q, dz_d;

  logic                   ge_s;
  logic [CMP_W-1:0]       rem_next_s;
  logic                   rem_next_zero_s;
  logic                   accept_s;
  logic                   calc_en_s;
  logic                   last_step_s;
  logic [DIVISOR_W-1:0]   in_divisor_s;
  logic [DIVIDEND_W-1:0]  in_dividend_s;

  assign in_divisor_s  = axis.s_axis_data[DIVISOR_W+DIVIDEND_W-1:DIVIDEND_W];
  assign in_dividend_s = axis.s_axis_data[DIVIDEND_W-1:0];

  div_cmp_sub_step #(
    .CMP_W(CMP_W)
  ) u_step (
    .rem_i              (rem_q),
    .cmp_i              (cmp_q),
    .ge_o               (ge_s),
    .rem_next_o         (rem_next_s),
    .rem_next_is_zero_o (rem_next_zero_s)
  );

  assign accept_s    = aclken & axis.s_axis_valid & (state_q == ST_IDLE);
  assign calc_en_s   = aclken & (state_q == ST_CALC);
  // A zero divisor finishes in one cycle; otherwise stop on the last bit or a zero remainder.
  assign last_step_s = dz_q | (k_q == {K_W{1'b0}}) | rem_next_zero_s;

  // Control FSM and quotient bit index; everything holds while aclken is low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      k_q     <= {K_W{1'b0}};
    end else if (aclken) begin
      case (state_q)
        ST_IDLE: begin
          if (axis.s_axis_valid) begin
            state_q <= ST_CALC;
            k_q     <= K_W'(DIVIDEND_W - 32'd1);
          end
        end
        ST_CALC: begin
          if (last_step_s) begin
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q - K_W'(1);
          end
        end
        ST_DONE: begin
          if (axis.m_axis_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath next-state: load operands on accept, one restoring step per CALC cycle.
  always_comb begin
    rem_d  = rem_q;
    cmp_d  = cmp_q;
    quo_d  = quo_q;
    user_d = user_q;
    dz_d   = dz_q;
    if (accept_s) begin
      rem_d  = CMP_W'(in_dividend_s);
      cmp_d  = {in_divisor_s, {(DIVIDEND_W-1){1'b0}}};
      quo_d  = {DIVIDEND_W{1'b0}};
      user_d = axis.s_axis_user;
      dz_d   = (in_divisor_s == {DIVISOR_W{1'b0}});
    end else if (calc_en_s) begin
      if (dz_q) begin
        // rem_q still holds the dividend, so the remainder field returns its low bits.
        quo_d = {DIVIDEND_W{1'b1}};
      end else begin
        rem_d      = rem_next_s;
        quo_d[k_q] = ge_s;
        cmp_d      = {1'b0, cmp_q[CMP_W-1:1]};
      end
    end else begin
      quo_d = quo_q;
    end
  end

  // Datapath registers carry no reset: they are only observed while m_axis_valid is high.
  always_ff @(posedge aclk) begin
    rem_q  <= rem_d;
    cmp_q  <= cmp_d;
    quo_q  <= quo_d;
    user_q <= user_d;
    dz_q   <= dz_d;
  end

  assign axis.s_axis_ready    = aclken & (state_q == ST_IDLE);
  assign axis.m_axis_valid    = aclken & (state_q == ST_DONE);
  assign axis.m_axis_data     = {rem_q[DIVISOR_W-1:0], quo_q};
  assign axis.m_axis_user     = user_q;
  assign axis.m_axis_div_zero = dz_q;

endmodule

// File: tb/tb_div_uint_multicycle.sv
// Scoreboard bench for div_uint_multicycle: a 16/3 instance and a 32/8 instance.
module tb_div_uint_multicycle;

  logic aclk = 1'b0;
  logic aresetn;
  logic aclken;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  div_uint_multicycle_if #(.DIVIDEND_W(16), .DIVISOR_W(3), .USER_W(1)) if1 ();
  div_uint_multicycle_if #(.DIVIDEND_W(32), .DIVISOR_W(8), .USER_W(1)) if2 ();

  div_uint_multicycle #(.DIVIDEND_W(16), .DIVISOR_W(3), .USER_W(1), .SIM_DELAY(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .axis(if1)
  );
  div_uint_multicycle #(.DIVIDEND_W(32), .DIVISOR_W(8), .USER_W(1), .SIM_DELAY(1)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .axis(if2)
  );

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   first1 = -1;
  int   first2 = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor for the 16-bit instance: compares every valid cycle, pops on handshake.
  always @(negedge aclk) begin
    if (if1.m_axis_valid === 1'b1) begin
      if (sb1.size() == 0) begin
        chk("d16 spurious_valid", 64'(if1.m_axis_valid), 64'd0);
      end else begin
        if (first1 < 0) begin
          first1 = cyc;
          chk("d16 latency", 64'(cyc - sb1[0].acc), 64'(sb1[0].lat));
        end
        chk("d16 data", 64'(if1.m_axis_data), sb1[0].data);
        chk("d16 user", 64'(if1.m_axis_user), 64'(sb1[0].user));
        chk("d16 div_zero", 64'(if1.m_axis_div_zero), 64'(sb1[0].dz));
        chk("d16 s_ready_in_done", 64'(if1.s_axis_ready), 64'd0);
        if (if1.m_axis_ready === 1'b1) begin
          void'(sb1.pop_front());
          first1 = -1;
        end
      end
    end else if (first1 >= 0 && aclken === 1'b1) begin
      chk("d16 valid_dropped", 64'(if1.m_axis_valid), 64'd1);
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge aclk) begin
    if (if2.m_axis_valid === 1'b1) begin
      if (sb2.size() == 0) begin
        chk("d32 spurious_valid", 64'(if2.m_axis_valid), 64'd0);
      end else begin
        if (first2 < 0) begin
          first2 = cyc;
          chk("d32 latency", 64'(cyc - sb2[0].acc), 64'(sb2[0].lat));
        end
        chk("d32 data", 64'(if2.m_axis_data), sb2[0].data);
        chk("d32 user", 64'(if2.m_axis_user), 64'(sb2[0].user));
        chk("d32 div_zero", 64'(if2.m_axis_div_zero), 64'(sb2[0].dz));
        if (if2.m_axis_ready === 1'b1) begin
          void'(sb2.pop_front());
          first2 = -1;
        end
      end
    end else if (first2 >= 0 && aclken === 1'b1) begin
      chk("d32 valid_dropped", 64'(if2.m_axis_valid), 64'd1);
    end
  end

  // n = CALC cycles plus any aclken-low cycles; expected latency is 1 + n.
  task automatic send(input int sel, input logic [7:0] dv, input logic [31:0] dd, input logic u,
                      input logic [31:0] eq, input logic [7:0] er, input logic ez,
                      input int n, input bit push);
    exp_t e;
    int   guard;
    logic rdy;
    @(posedge aclk); #1;
    if (sel == 0) begin
      if1.s_axis_data  = {dv[2:0], dd[15:0]};
      if1.s_axis_user  = u;
      if1.s_axis_valid = 1'b1;
    end else begin
      if2.s_axis_data  = {dv, dd};
      if2.s_axis_user  = u;
      if2.s_axis_valid = 1'b1;
    end
    guard = 0;
    forever begin
      @(negedge aclk);
      rdy = (sel == 0) ? if1.s_axis_ready : if2.s_axis_ready;
      if (rdy === 1'b1) break;
      guard++;
      if (guard > 200) begin
        chk("accept_timeout s_ready", 64'(rdy), 64'd1);
        break;
      end
    end
    e.data = (sel == 0) ? {45'd0, er[2:0], eq[15:0]} : {24'd0, er, eq};
    e.user = u;
    e.dz   = ez;
    e.lat  = 1 + n;
    e.acc  = cyc;
    if (push && rdy === 1'b1) begin
      if (sel == 0) sb1.push_back(e);
      else          sb2.push_back(e);
    end
    @(posedge aclk); #1;
    if1.s_axis_valid = 1'b0;
    if2.s_axis_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && guard < 300) begin
      @(negedge aclk);
      guard++;
    end
    chk("drain_timeout pending", 64'(sb1.size() + sb2.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int guard;
    aresetn = 1'b0;
    aclken  = 1'b1;
    if1.s_axis_data = '0; if1.s_axis_user = 1'b0; if1.s_axis_valid = 1'b0; if1.m_axis_ready = 1'b1;
    if2.s_axis_data = '0; if2.s_axis_user = 1'b0; if2.s_axis_valid = 1'b0; if2.m_axis_ready = 1'b1;
    repeat (2) @(negedge aclk);
    chk("reset d16 m_valid", 64'(if1.m_axis_valid), 64'd0);
    chk("reset d16 s_ready", 64'(if1.s_axis_ready), 64'd1);
    chk("reset d32 m_valid", 64'(if2.m_axis_valid), 64'd0);
    chk("reset d32 s_ready", 64'(if2.s_axis_ready), 64'd1);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // 16/3 instance: sel, divisor, dividend, user, quotient, remainder, div_zero, n, push
    send(0, 8'd7, 32'd100,     1'b0, 32'd14,     8'd2, 1'b0, 16, 1'b1); drain();
    send(0, 8'd4, 32'h8000,    1'b1, 32'h2000,   8'd0, 1'b0, 3,  1'b1); drain();
    send(0, 8'd0, 32'h1234,    1'b1, 32'hFFFF,   8'd4, 1'b1, 1,  1'b1); drain();

    // Hold m_axis_ready low: result must stay put and s_axis_ready stay low.
    @(posedge aclk); #1;
    if1.m_axis_ready = 1'b0;
    send(0, 8'd5, 32'd0,       1'b1, 32'd0,      8'd0, 1'b0, 1,  1'b1);
    guard = 0;
    while (if1.m_axis_valid !== 1'b1 && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    chk("backpressure m_valid seen", 64'(if1.m_axis_valid), 64'd1);
    repeat (5) @(negedge aclk);
    @(posedge aclk); #1;
    if1.m_axis_ready = 1'b1;
    drain();

    // aclken low for three cycles in the middle of CALC.
    send(0, 8'd3, 32'd1000,    1'b1, 32'd333,    8'd1, 1'b0, 19, 1'b1);
    repeat (4) @(posedge aclk); #1;
    aclken = 1'b0;
    repeat (3) @(posedge aclk); #1;
    aclken = 1'b1;
    drain();

    // Reset in the middle of CALC discards the operation.
    send(0, 8'd3, 32'd500,     1'b0, 32'd0,      8'd0, 1'b0, 0,  1'b0);
    repeat (3) @(posedge aclk); #1;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("midrst d16 m_valid", 64'(if1.m_axis_valid), 64'd0);
    chk("midrst d16 s_ready", 64'(if1.s_axis_ready), 64'd1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("postrst d16 m_valid", 64'(if1.m_axis_valid), 64'd0);
    chk("postrst d16 s_ready", 64'(if1.s_axis_ready), 64'd1);

    // Back-to-back operations, including min/max operands.
    send(0, 8'd6, 32'd48,      1'b0, 32'd8,      8'd0, 1'b0, 13, 1'b1);
    send(0, 8'd7, 32'hFFFF,    1'b1, 32'h2492,   8'd1, 1'b0, 16, 1'b1);
    send(0, 8'd7, 32'd7,       1'b0, 32'd1,      8'd0, 1'b0, 16, 1'b1);
    send(0, 8'd0, 32'd0,       1'b1, 32'hFFFF,   8'd0, 1'b1, 1,  1'b1);
    send(0, 8'd1, 32'hFFFF,    1'b0, 32'hFFFF,   8'd0, 1'b0, 16, 1'b1);
    send(0, 8'd7, 32'd1,       1'b1, 32'd0,      8'd1, 1'b0, 16, 1'b1);
    drain();

    // 32/8 instance.
    send(1, 8'hFF, 32'hFFFFFFFF, 1'b1, 32'h01010101, 8'h00, 1'b0, 32, 1'b1);
    send(1, 8'h80, 32'h80000000, 1'b0, 32'h01000000, 8'h00, 1'b0, 8,  1'b1);
    send(1, 8'hFF, 32'h00000001, 1'b1, 32'h00000000, 8'h01, 1'b0, 32, 1'b1);
    send(1, 8'h00, 32'h12345678, 1'b1, 32'hFFFFFFFF, 8'h78, 1'b1, 1,  1'b1);
    send(1, 8'h01, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 8'h00, 1'b0, 32, 1'b1);
    send(1, 8'h07, 32'd100,      1'b0, 32'd14,       8'h02, 1'b0, 32, 1'b1);
    drain();

    repeat (3) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
